// File: rtl/bcd_scan_pkg.sv
// Shared constants for the BCD scan display: active-high {g..a} segment
// patterns and the digit-slot index type.
package bcd_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ONES     = 2'd0,
    TENS     = 2'd1,
    HUNDREDS = 2'd2
  } digit_idx_t;

endpackage

// File: rtl/bcd_scan_display_seg7_decode.sv
// Combinational 4-bit digit to active-high {g..a} segment decode.
// Non-decimal codes 10..15 render as a dash.
module seg7_decode
  import bcd_scan_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Three-digit multiplexed 7-segment driver for a packed BCD value, with a
// one-deep pending slot committed only at frame end. Define BCD_SCAN_LZB_EN
// to blank leading zeros on the hundreds and tens digits.
module bcd_scan_display
  import bcd_scan_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bcd_valid,
  output logic       bcd_ready,
  input  logic [9:0] bcd_in,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [2:0]      AN_OFF   = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_idx;
  logic [9:0]       r_pend;
  logic [9:0]       r_disp;
  logic             r_full;
  logic             r_err;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;

  logic       w_tick;
  logic       w_frame_end;
  logic       w_load;
  logic       w_commit;
  logic       w_pend_bad;
  logic       w_guard;
  logic       w_blank;
  logic [3:0] w_digit;
  logic [2:0] w_an_hot;
  logic [6:0] w_seg_hi;

  assign w_tick      = (r_cnt == CNT_LAST);
  assign w_frame_end = w_tick && (r_idx == HUNDREDS);
  assign w_load      = bcd_valid && !r_full;
  assign w_commit    = w_frame_end && r_full;
  assign w_pend_bad  = (r_pend[7:4] > 4'd9) || (r_pend[3:0] > 4'd9);
  assign w_guard     = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= ONES;
    end else if (w_tick) begin
      case (r_idx)
        ONES:    r_idx <= TENS;
        TENS:    r_idx <= HUNDREDS;
        default: r_idx <= ONES;
      endcase
    end
  end

  // The slot is full whenever ready is low, so a load and a commit can never
  // coincide; a load on an empty-slot frame end waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_pend <= '0;
      r_disp <= '0;
      r_err  <= 1'b0;
    end else if (w_commit) begin
      r_disp <= r_pend;
      r_full <= 1'b0;
      r_err  <= w_pend_bad;
    end else if (w_load) begin
      r_pend <= bcd_in;
      r_full <= 1'b1;
    end
  end

  always_comb begin
    w_digit  = r_disp[3:0];
    w_an_hot = 3'b001;
    case (r_idx)
      TENS: begin
        w_digit  = r_disp[7:4];
        w_an_hot = 3'b010;
      end
      HUNDREDS: begin
        w_digit  = {2'b00, r_disp[9:8]};
        w_an_hot = 3'b100;
      end
      default: begin
        w_digit  = r_disp[3:0];
        w_an_hot = 3'b001;
      end
    endcase
  end

`ifdef BCD_SCAN_LZB_EN
  assign w_blank = ((r_idx == HUNDREDS) && (r_disp[9:8] == 2'd0)) ||
                   ((r_idx == TENS) && (r_disp[9:4] == 6'd0));
`else
  assign w_blank = 1'b0;
`endif

  seg7_decode u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg_hi)
  );

  // Anodes go dark for the first cycle of each slot so the previous digit's
  // segments never flash on the newly selected anode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else if (w_guard || w_blank) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= AN_ACTIVE_LOW ? ~w_an_hot : w_an_hot;
      r_seg <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
    end
  end

  assign bcd_ready = !r_full;
  assign err       = r_err;
  assign an        = r_an;
  assign seg       = r_seg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with REFRESH_DIV=4 and active-low
// segments and anodes; one frame is 12 cycles, frame-end edges at 12, 24, ...
module tb_bcd_scan_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bcd_valid;
  logic       bcd_ready;
  logic [9:0] bcd_in;
  logic [6:0] seg;
  logic [2:0] an;
  logic       err;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  bcd_scan_display #(
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .bcd_in    (bcd_in),
    .seg       (seg),
    .an        (an),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] lo(input logic [6:0] p);
    return ~p;
  endfunction

  // Advance to the negedge following posedge number 'target' since release.
  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic chk_slot(input string tag, input logic [2:0] an_exp, input logic [6:0] seg_exp);
    chk({tag, ".an"}, an, an_exp);
    chk({tag, ".seg"}, seg, seg_exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    bcd_valid = 1'b0;
    bcd_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.an", an, 3'b111);
    chk("rst.seg", seg, 7'h7F);
    chk("rst.ready", bcd_ready, 1'b1);
    chk("rst.err", err, 1'b0);
    rst_n = 1'b1;
    cyc   = 0;

    step_to(1);
    chk("init.guard", an, 3'b111);
    step_to(2);
    chk_slot("init.ones", 3'b110, lo(7'h3F));

    // 253
    bcd_valid = 1'b1;
    bcd_in    = 10'h253;
    step_to(3);
    bcd_valid = 1'b0;
    chk("253.ready_lo", bcd_ready, 1'b0);
    step_to(11);
    chk("253.ready_hold", bcd_ready, 1'b0);
    step_to(12);
    chk("253.ready_up", bcd_ready, 1'b1);
    chk("253.err", err, 1'b0);

    // 012 accepted, 034 held against back-pressure
    bcd_valid = 1'b1;
    bcd_in    = 10'h012;
    step_to(13);
    chk("253.g0", an, 3'b111);
    bcd_in = 10'h034;
    step_to(14);
    chk_slot("253.ones", 3'b110, lo(7'h4F));
    step_to(17);
    chk("253.g1", an, 3'b111);
    step_to(18);
    chk_slot("253.tens", 3'b101, lo(7'h6D));
    step_to(21);
    chk("253.g2", an, 3'b111);
    step_to(22);
    chk_slot("253.hund", 3'b011, lo(7'h5B));
    step_to(23);
    chk("bp.ready_lo", bcd_ready, 1'b0);
    step_to(24);
    chk("bp.ready_up", bcd_ready, 1'b1);
    step_to(25);
    chk("bp.accept", bcd_ready, 1'b0);
    bcd_valid = 1'b0;
    step_to(26);
    chk_slot("012.ones", 3'b110, lo(7'h5B));
    step_to(30);
    chk_slot("012.tens", 3'b101, lo(7'h06));
    step_to(34);
`ifdef BCD_SCAN_LZB_EN
    chk("012.hund_blank", an, 3'b111);
`else
    chk_slot("012.hund", 3'b011, lo(7'h3F));
`endif
    step_to(36);
    chk("034.ready_up", bcd_ready, 1'b1);

    // Non-decimal tens digit
    bcd_valid = 1'b1;
    bcd_in    = 10'h0C1;
    step_to(37);
    bcd_valid = 1'b0;
    step_to(38);
    chk_slot("034.ones", 3'b110, lo(7'h66));
    step_to(42);
    chk_slot("034.tens", 3'b101, lo(7'h4F));
    step_to(47);
    chk("0C1.err_pre", err, 1'b0);
    step_to(48);
    chk("0C1.err_set", err, 1'b1);
    bcd_valid = 1'b1;
    bcd_in    = 10'h000;
    step_to(49);
    bcd_valid = 1'b0;
    step_to(50);
    chk_slot("0C1.ones", 3'b110, lo(7'h06));
    step_to(54);
    chk_slot("0C1.tens_dash", 3'b101, lo(7'h40));
    step_to(59);
    chk("000.err_hold", err, 1'b1);
    step_to(60);
    chk("000.err_clr", err, 1'b0);

    // Leading zeros
    bcd_valid = 1'b1;
    bcd_in    = 10'h007;
    step_to(61);
    bcd_valid = 1'b0;
    step_to(74);
    chk_slot("007.ones", 3'b110, lo(7'h07));
`ifdef BCD_SCAN_LZB_EN
    for (int c = 77; c <= 84; c++) begin
      step_to(c);
      chk("007.lzb_an", an, 3'b111);
    end
`else
    step_to(78);
    chk_slot("007.tens", 3'b101, lo(7'h3F));
    step_to(82);
    chk_slot("007.hund", 3'b011, lo(7'h3F));
    step_to(84);
`endif

    // Reset with the slot full mid-frame
    bcd_valid = 1'b1;
    bcd_in    = 10'h199;
    step_to(85);
    bcd_valid = 1'b0;
    chk("199.loaded", bcd_ready, 1'b0);
    step_to(88);
    rst_n = 1'b0;
    #1;
    chk("mrst.an", an, 3'b111);
    chk("mrst.seg", seg, 7'h7F);
    chk("mrst.ready", bcd_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    step_to(2);
    chk_slot("mrst.ones", 3'b110, lo(7'h3F));
    step_to(14);
    chk_slot("mrst.ones2", 3'b110, lo(7'h3F));
    chk("mrst.ready2", bcd_ready, 1'b1);
    step_to(18);
`ifdef BCD_SCAN_LZB_EN
    chk("mrst.tens_blank", an, 3'b111);
`else
    chk_slot("mrst.tens", 3'b101, lo(7'h3F));
`endif
    step_to(22);
`ifdef BCD_SCAN_LZB_EN
    chk("mrst.hund_blank", an, 3'b111);
`else
    chk_slot("mrst.hund", 3'b011, lo(7'h3F));
`endif
    chk("mrst.err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
